// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first,
// one bit per clock, with a registered carry between bits.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] shift_a, shift_b, shift_s, shift_s_next;
   logic [CW-1:0]    cnt;
   logic             carry, fa_sum, fa_carry, last_bit;

   assign fa_sum   = shift_a[0] ^ shift_b[0] ^ carry;
   assign fa_carry = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_one
         assign shift_s_next = fa_sum;
      end else begin : g_many
         assign shift_s_next = {fa_sum, shift_s[WIDTH-1:1]};
      end
   endgenerate

   // Handshake: start is only accepted while busy is low; done pulses for one
   // cycle with sum/cout already valid, and start during busy is dropped.
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shift_a <= '0;
         shift_b <= '0;
         shift_s <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_a <= a;
                  shift_b <= b;
                  carry   <= cin;
                  cnt     <= '0;
                  shift_s <= '0;
               end
            end
            RUN: begin
               shift_a <= shift_a >> 1;
               shift_b <= shift_b >> 1;
               shift_s <= shift_s_next;
               carry   <= fa_carry;
               cnt     <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= shift_s_next;
                  cout <= fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for timing and
// handshake scenarios and a 1-bit instance for the full-adder truth table.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       cin;
   logic       busy, done, cout;
   logic [7:0] sum;
   logic [1:0] dbg_state;

   logic       start1, a1, b1, cin1;
   logic       busy1, done1, sum1, cout1;
   logic [1:0] dbg_state1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .dbg_state(dbg_state)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .dbg_state(dbg_state1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit operation: accept, then watch 20 cycles. Cycle index 0 is the
   // first cycle after the accept edge; done is expected at index 8 and busy
   // for indices 0..8. repulse_at >= 0 re-pulses start with other operands.
   task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [7:0] exp_s, input logic exp_c,
                       input logic [7:0] prev_s, input logic prev_c, input int repulse_at);
      int done_at, done_cnt, busy_cnt;
      bit held_ok;
      done_at = -1; done_cnt = 0; busy_cnt = 0; held_ok = 1'b1;
      a = ta; b = tb_; cin = tc; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == repulse_at) begin start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0; end
         if (i == repulse_at + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end else if (done_at < 0 && (sum !== prev_s || cout !== prev_c)) begin
            held_ok = 1'b0;
         end
         step();
      end
      total++; if (done_at !== 8) begin bad++; $display("FAIL %s done_index got=%0d want=8", name, done_at); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt); end
      total++; if (busy_cnt !== 9) begin bad++; $display("FAIL %s busy_cycles got=%0d want=9", name, busy_cnt); end
      total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL %s prev_result_held got=0 want=1", name); end
      total++; if (sum !== exp_s) begin bad++; $display("FAIL %s sum got=%h want=%h", name, sum, exp_s); end
      total++; if (cout !== exp_c) begin bad++; $display("FAIL %s cout got=%b want=%b", name, cout, exp_c); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      step(); step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
      total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset sum got=%h want=00", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset cout got=%b want=0", cout); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset state got=%0d want=0", dbg_state); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset busy1 got=%b want=0", busy1); end
      start = 1'b0; start1 = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0, -1);
   endtask

   task automatic test_carry();
      run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, -1);
      run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, -1);
   endtask

   task automatic test_ignored_start();
      run8("repulse", 8'h23, 8'h45, 1'b0, 8'h68, 1'b0, 8'hFF, 1'b1, 2);
   endtask

   task automatic test_abort();
      bit done_seen;
      done_seen = 1'b0;
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b want=0", busy); end
      total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort sum got=%h want=00", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort cout got=%b want=0", cout); end
      for (int i = 0; i < 12; i++) begin
         if (done || busy) done_seen = 1'b1;
         step();
      end
      total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_quiet activity got=1 want=0"); end
      run8("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h00, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      int pulses, last_at, gap_bad, val_bad;
      pulses = 0; last_at = -1; gap_bad = 0; val_bad = 0;
      a = 8'h10; b = 8'h20; cin = 1'b1; start = 1'b1;
      for (int i = 0; i < 36; i++) begin
         step();
         if (done) begin
            if (last_at >= 0 && (i - last_at) != 10) gap_bad++;
            if (sum !== 8'h31 || cout !== 1'b0) val_bad++;
            last_at = i;
            pulses++;
         end
      end
      start = 1'b0;
      for (int i = 0; i < 12; i++) step();
      total++; if (pulses !== 3) begin bad++; $display("FAIL b2b pulses got=%0d want=3", pulses); end
      total++; if (gap_bad !== 0) begin bad++; $display("FAIL b2b spacing bad_gaps=%0d want=0", gap_bad); end
      total++; if (val_bad !== 0) begin bad++; $display("FAIL b2b result bad_results=%0d want=0", val_bad); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b idle busy got=%b want=0", busy); end
   endtask

   task automatic test_width1();
      logic [1:0] exp_tab [8];
      logic [2:0] v;
      int done_at;
      exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
         step();
         start1 = 1'b0;
         done_at = -1;
         for (int i = 0; i < 4; i++) begin
            if (done1 && done_at < 0) begin
               done_at = i;
               total++;
               if ({cout1, sum1} !== exp_tab[k]) begin
                  bad++; $display("FAIL w1_sum abc=%b got=%b want=%b", v, {cout1, sum1}, exp_tab[k]);
               end
            end
            step();
         end
         total++; if (done_at !== 1) begin bad++; $display("FAIL w1_done_index abc=%b got=%0d want=1", v, done_at); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignored_start();
      test_abort();
      test_back_to_back();
      test_width1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
